ex_stage: RTL
=============

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL provide clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL provide rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL provide ex_aluop, input, 8, operation code from the ID/EX register.
REQ-004 SHALL provide ex_rs_data, input, 32, operand A (rs).
REQ-005 SHALL provide ex_rt_data, input, 32, operand B (rt).
REQ-006 SHALL provide ex_w_reg_addr, input, 5, destination register address.
REQ-007 SHALL provide ex_wd, input, 1, destination write enable.
REQ-008 SHALL provide mem_w_reg_addr, output, 5, destination address to MEM.
REQ-009 SHALL provide mem_wd, output, 1, write enable to MEM.
REQ-010 SHALL provide mem_w_data, output, 32, result to MEM.
REQ-011 SHALL provide stallreq, output, 1, request to freeze PC, IF/ID and ID/EX.
REQ-012 SHALL provide hi_o, output, 32, and lo_o, output, 32, current HI and LO register values.

Function
REQ-013 SHALL decode aluop 8'h24 AND, 8'h25 OR, 8'h26 XOR, 8'h27 NOR, 8'h21 ADDU, 8'h23 SUBU, 8'h2A SLT (signed), 8'h2B SLTU; result is combinational, 32-bit, mod 2^32, no overflow trap.
REQ-014 SHALL decode 8'h10 MFHI (result=HI) and 8'h12 MFLO (result=LO), reading the registered HI/LO value.
REQ-015 SHALL decode 8'h11 MTHI and 8'h13 MTLO: HI or LO <= rs at the clock edge; mem_wd=0.
REQ-016 SHALL decode 8'h18 MULT (signed) and 8'h19 MULTU: {HI,LO} <= 64-bit product at the clock edge; mem_wd=0; no stall.
REQ-017 SHALL decode 8'h1A DIV (signed) and 8'h1B DIVU via an iterative 1-bit-per-cycle restoring divider; mem_wd=0.
REQ-018 SHALL pass mem_w_reg_addr=ex_w_reg_addr and mem_wd=ex_wd for ALU/MF ops; aluop 8'h00 and unknown codes give mem_w_data=0 with ex_wd passed through.
REQ-019 Divider FSM SHALL have states IDLE, BUSY, DONE.
REQ-020 IDLE with DIV/DIVU and nonzero rt: latch |rs|,|rt| (signed) or raw values (unsigned), count=0, go BUSY.
REQ-021 BUSY SHALL run exactly 32 iterations (count 0..31), then go DONE.
REQ-022 DONE SHALL write LO=quotient, HI=remainder at its clock edge, then return to IDLE unconditionally.
REQ-023 Signed results: quotient negated when rs[31]^rt[31]; remainder takes sign of rs.
REQ-024 Divide by zero SHALL go IDLE->DONE directly with LO=32'hFFFF_FFFF, HI=rs.
REQ-025 stallreq SHALL be 1 in IDLE while aluop is DIV/DIVU, and throughout BUSY; 0 in DONE and otherwise; DIV stalls 33 cycles (zero divisor 1 cycle).
REQ-026 While stallreq=1, mem_wd SHALL be 0 (bubble to MEM).
REQ-027 Inputs SHALL be sampled only when latched in IDLE; upstream holds them stable during stall.
REQ-028 HI/LO SHALL update only at rising clk edges; no same-cycle forwarding of a write to MFHI/MFLO.

Reset
REQ-029 With rst=1 at a clk edge: FSM=IDLE, count=0, HI=LO=0.
REQ-030 While rst=1: mem_wd=0, mem_w_data=0, mem_w_reg_addr=0, stallreq=0; reset mid-division aborts with HI/LO=0.

Verification
REQ-031 ADDU rs=32'hFFFF_FFFF, rt=1, wd=1, addr=5 -> mem_w_data=0, mem_wd=1, mem_w_reg_addr=5.
REQ-032 SLT rs=32'hFFFF_FFFF, rt=1 -> 1; SLTU same operands -> 0.
REQ-033 MULT rs=-3, rt=4 then MFHI, MFLO -> HI=32'hFFFF_FFFF, LO=32'hFFFF_FFF4.
REQ-034 DIV rs=-7, rt=2 -> stallreq high 33 cycles, then LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF.
REQ-035 DIVU rs=100, rt=0 -> stallreq 1 cycle, LO=32'hFFFF_FFFF, HI=100.
REQ-036 rst asserted at cycle 10 of DIV -> next cycle stallreq=0, HI=LO=0, FSM IDLE.

Source files
------------

// File: rtl/ex_stage_if.sv
// ex_stage_if -- bundle between the ID/EX register, the EX stage and EX/MEM.
//
// Handshake: an instruction on the ex_* fields is consumed by the EX stage on
// the first rising clk edge at which stallreq is 0.  While stallreq is 1 the
// upstream stages hold every ex_* field stable and the stage sends a bubble
// (mem_wd = 0) downstream.
//
// Signals
//   ex_aluop       [7:0]  operation code from ID/EX
//   ex_rs_data     [31:0] operand A (rs)
//   ex_rt_data     [31:0] operand B (rt)
//   ex_w_reg_addr  [4:0]  destination register address
//   ex_wd                 destination write enable
//   mem_w_reg_addr [4:0]  destination address to MEM
//   mem_wd                write enable to MEM
//   mem_w_data     [31:0] result to MEM
//   stallreq              freeze PC, IF/ID and ID/EX
//   hi_o, lo_o     [31:0] current HI / LO register values
//   div_state      [1:0]  divider FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Modports: master = pipeline side that drives ex_*, slave = ex_stage.
interface ex_stage_if;
   logic [7:0]  ex_aluop;
   logic [31:0] ex_rs_data;
   logic [31:0] ex_rt_data;
   logic [4:0]  ex_w_reg_addr;
   logic        ex_wd;
   logic [4:0]  mem_w_reg_addr;
   logic        mem_wd;
   logic [31:0] mem_w_data;
   logic        stallreq;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic [1:0]  div_state;

   modport master (
      output ex_aluop, ex_rs_data, ex_rt_data, ex_w_reg_addr, ex_wd,
      input  mem_w_reg_addr, mem_wd, mem_w_data, stallreq, hi_o, lo_o,
             div_state
   );

   modport slave (
      input  ex_aluop, ex_rs_data, ex_rt_data, ex_w_reg_addr, ex_wd,
      output mem_w_reg_addr, mem_wd, mem_w_data, stallreq, hi_o, lo_o,
             div_state
   );
endinterface

// File: rtl/ex_stage.sv
// ex_stage -- execute stage of a 5-stage MIPS-style pipeline.
//
// Combinational ALU (logic, add/sub, set-less-than), HI/LO register file with
// MTHI/MTLO/MFHI/MFLO, single-cycle 32x32 multiply into {HI,LO}, and an
// iterative restoring divider (one quotient bit per clock) that stalls the
// front of the pipeline while it runs.
//
// Ports
//   clk  rising-edge clock for all state
//   rst  synchronous active-high reset
//   bus  ex_stage_if.slave (instruction in, result out, stallreq, HI/LO,
//        divider state for observation)
module ex_stage (
   input  logic      clk,
   input  logic      rst,
   ex_stage_if.slave bus
);

   localparam logic [7:0] OP_NOP   = 8'h00;
   localparam logic [7:0] OP_MFHI  = 8'h10;
   localparam logic [7:0] OP_MTHI  = 8'h11;
   localparam logic [7:0] OP_MFLO  = 8'h12;
   localparam logic [7:0] OP_MTLO  = 8'h13;
   localparam logic [7:0] OP_MULT  = 8'h18;
   localparam logic [7:0] OP_MULTU = 8'h19;
   localparam logic [7:0] OP_DIV   = 8'h1A;
   localparam logic [7:0] OP_DIVU  = 8'h1B;
   localparam logic [7:0] OP_ADDU  = 8'h21;
   localparam logic [7:0] OP_SUBU  = 8'h23;
   localparam logic [7:0] OP_AND   = 8'h24;
   localparam logic [7:0] OP_OR    = 8'h25;
   localparam logic [7:0] OP_XOR   = 8'h26;
   localparam logic [7:0] OP_NOR   = 8'h27;
   localparam logic [7:0] OP_SLT   = 8'h2A;
   localparam logic [7:0] OP_SLTU  = 8'h2B;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } div_state_t;

   div_state_t  state_q, state_d;

   logic [7:0]  op;
   logic [31:0] rs, rt;
   logic        is_div, is_sdiv, rt_zero;
   logic [31:0] rs_abs, rt_abs;

   // Divider working registers
   logic [4:0]  count_q;
   logic [31:0] quo_q;      // dividend shifting out, quotient shifting in
   logic [31:0] rem_q;      // partial remainder
   logic [31:0] dvs_q;      // divisor magnitude
   logic [31:0] rs_raw_q;   // original rs, for the divide-by-zero result
   logic        neg_quo_q, neg_rem_q, zero_q;

   logic [32:0] rem_shift, trial_diff;
   logic        trial_ok;
   logic [31:0] quo_fix, rem_fix;

   logic [31:0] hi_q, lo_q;
   logic [63:0] prod_s, prod_u;
   logic [31:0] alu_result;
   logic        no_writeback;
   logic        stall;
   logic        div_write;

   assign op      = bus.ex_aluop;
   assign rs      = bus.ex_rs_data;
   assign rt      = bus.ex_rt_data;
   assign is_div  = (op == OP_DIV) || (op == OP_DIVU);
   assign is_sdiv = (op == OP_DIV);
   assign rt_zero = (rt == 32'd0);

   // Signed divide works on magnitudes; 32'h8000_0000 maps onto itself,
   // which is the correct unsigned magnitude.
   assign rs_abs = (is_sdiv && rs[31]) ? (32'd0 - rs) : rs;
   assign rt_abs = (is_sdiv && rt[31]) ? (32'd0 - rt) : rt;

   // ------------------------------------------------------------------
   // Divider FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Divider FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (is_div) state_d = rt_zero ? S_DONE : S_BUSY;
         end
         S_BUSY: begin
            if (count_q == 5'd31) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Divider FSM: outputs
   always_comb begin
      stall     = 1'b0;
      div_write = 1'b0;
      if (!rst) begin
         case (state_q)
            S_IDLE:  stall = is_div;
            S_BUSY:  stall = 1'b1;
            S_DONE:  div_write = 1'b1;
            default: stall = 1'b0;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Restoring divide step: shift one dividend bit into the remainder and
   // subtract the divisor if it fits (no borrow out of bit 32).
   // ------------------------------------------------------------------
   assign rem_shift  = {rem_q, quo_q[31]};
   assign trial_diff = rem_shift - {1'b0, dvs_q};
   assign trial_ok   = ~trial_diff[32];

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= 5'd0;
         quo_q     <= 32'd0;
         rem_q     <= 32'd0;
         dvs_q     <= 32'd0;
         rs_raw_q  <= 32'd0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         zero_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (is_div) begin
                  count_q   <= 5'd0;
                  quo_q     <= rs_abs;
                  rem_q     <= 32'd0;
                  dvs_q     <= rt_abs;
                  rs_raw_q  <= rs;
                  neg_quo_q <= is_sdiv & (rs[31] ^ rt[31]);
                  neg_rem_q <= is_sdiv & rs[31];
                  zero_q    <= rt_zero;
               end
            end
            S_BUSY: begin
               rem_q   <= trial_ok ? trial_diff[31:0] : rem_shift[31:0];
               quo_q   <= {quo_q[30:0], trial_ok};
               count_q <= count_q + 5'd1;
            end
            default: ;
         endcase
      end
   end

   // Quotient negated for opposite signs, remainder follows the dividend.
   assign quo_fix = neg_quo_q ? (32'd0 - quo_q) : quo_q;
   assign rem_fix = neg_rem_q ? (32'd0 - rem_q) : rem_q;

   // ------------------------------------------------------------------
   // HI/LO registers. Writes land at the clock edge only, so an MFHI/MFLO
   // issued together with a write still sees the old value.
   // ------------------------------------------------------------------
   assign prod_u = {32'd0, rs} * {32'd0, rt};
   assign prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q <= 32'd0;
         lo_q <= 32'd0;
      end else if (div_write) begin
         if (zero_q) begin
            lo_q <= 32'hFFFF_FFFF;
            hi_q <= rs_raw_q;
         end else begin
            lo_q <= quo_fix;
            hi_q <= rem_fix;
         end
      end else begin
         case (op)
            OP_MTHI:  hi_q <= rs;
            OP_MTLO:  lo_q <= rs;
            OP_MULT:  {hi_q, lo_q} <= prod_s;
            OP_MULTU: {hi_q, lo_q} <= prod_u;
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Combinational result path
   // ------------------------------------------------------------------
   always_comb begin
      alu_result   = 32'd0;
      no_writeback = 1'b0;
      case (op)
         OP_AND:  alu_result = rs & rt;
         OP_OR:   alu_result = rs | rt;
         OP_XOR:  alu_result = rs ^ rt;
         OP_NOR:  alu_result = ~(rs | rt);
         OP_ADDU: alu_result = rs + rt;
         OP_SUBU: alu_result = rs - rt;
         OP_SLT:  alu_result = {31'd0, ($signed(rs) < $signed(rt))};
         OP_SLTU: alu_result = {31'd0, (rs < rt)};
         OP_MFHI: alu_result = hi_q;
         OP_MFLO: alu_result = lo_q;
         OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU:
                  no_writeback = 1'b1;
         OP_NOP:  alu_result = 32'd0;
         default: alu_result = 32'd0;
      endcase
   end

   assign bus.mem_w_data     = rst ? 32'd0 : alu_result;
   assign bus.mem_w_reg_addr = rst ? 5'd0 : bus.ex_w_reg_addr;
   assign bus.mem_wd         = (rst || stall || no_writeback) ? 1'b0 : bus.ex_wd;
   assign bus.stallreq       = stall;
   assign bus.hi_o           = hi_q;
   assign bus.lo_o           = lo_q;
   assign bus.div_state      = state_q;

endmodule
